split_radio_power_sequencer: RTL and testbench

Sequences the split-radio front end: brings up the ± supply rails for the split radio, then the LNA, then time-multiplexes the two received streams (1236 band, 5478 band) onto one sample output. Ramps down in reverse order and latches a fault if a rail drops while powered. Sits between the rail generator, `PowerLNA` and `SplitRadio` in the link-power top level, clocked from the 100 MHz crystal-derived clock.

---
 rtl/split_radio_pkg.sv | 17 +
 rtl/split_radio_power_sequencer_if.sv | 30 +++
 rtl/sr_settle_counter.sv | 27 ++
 rtl/split_radio_power_sequencer.sv | 161 ++++++++++++++++
 tb/tb_split_radio_power_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/split_radio_pkg.sv
// Shared types for the split-radio power sequencer: FSM state encoding and
// the channel-select encodings used on ChannelSelect.
package split_radio_pkg;

    typedef enum logic [2:0] {
        OFF,
        RAILS_UP,
        LNA_UP,
        RECEIVE,
        RAMP_DOWN,
        FAULT
    } sr_state_t;

    localparam logic CH_1236 = 1'b0;
    localparam logic CH_5478 = 1'b1;

endpackage

// File: rtl/split_radio_power_sequencer_if.sv
// Signal bundle between the sequencer and the rail generator / LNA / split radio.
// The slave modport is the sequencer's view; master is the surrounding board logic.
interface split_radio_power_sequencer_if;

    logic PowerRequest;
    logic RailGood;
    logic Received1236;
    logic Received5478;
    logic EnableVplus;
    logic EnableVminus;
    logic EnableLna;
    logic ChannelSelect;
    logic ReceivedSample;
    logic SampleValid;
    logic Ready;
    logic Fault;

    modport master (
        output PowerRequest, RailGood, Received1236, Received5478,
        input  EnableVplus, EnableVminus, EnableLna, ChannelSelect,
               ReceivedSample, SampleValid, Ready, Fault
    );

    modport slave (
        input  PowerRequest, RailGood, Received1236, Received5478,
        output EnableVplus, EnableVminus, EnableLna, ChannelSelect,
               ReceivedSample, SampleValid, Ready, Fault
    );

endinterface

// File: rtl/sr_settle_counter.sv
// Loadable down-counter shared by every timed state of the sequencer.
// Holds at zero instead of wrapping; Done is high whenever the count is zero.
module sr_settle_counter #(
    parameter int CountWidth = 16
) (
    input  logic                  Clock100Mhz,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [CountWidth-1:0] LoadValue,
    output logic                  Done
);

    logic [CountWidth-1:0] count;

    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            count <= '0;
        end else if (Load) begin
            count <= LoadValue;
        end else if (count != '0) begin
            count <= count - CountWidth'(1);
        end
    end

    assign Done = (count == '0);

endmodule

// File: rtl/split_radio_power_sequencer.sv
// Powers the split-radio front end rails -> LNA -> receive, alternating the two
// received bands onto one sample output; ramps down in reverse and latches rail faults.
module split_radio_power_sequencer
    import split_radio_pkg::*;
#(
    parameter int SettleCycles    = 16,
    parameter int LnaSettleCycles = 8,
    parameter int DwellCycles     = 32,
    parameter int RampDownCycles  = 8,
    parameter int CountWidth      = 16
) (
    input logic                          Clock100Mhz,
    input logic                          Reset,
    split_radio_power_sequencer_if.slave radio
);

    localparam logic [CountWidth-1:0] SettleLoad   = CountWidth'(SettleCycles - 1);
    localparam logic [CountWidth-1:0] LnaSettleLoad = CountWidth'(LnaSettleCycles - 1);
    localparam logic [CountWidth-1:0] DwellLoad    = CountWidth'(DwellCycles - 1);
    localparam logic [CountWidth-1:0] RampDownLoad = CountWidth'(RampDownCycles - 1);

    sr_state_t             state;
    sr_state_t             nextState;
    logic                  counterLoad;
    logic [CountWidth-1:0] counterLoadValue;
    logic                  counterDone;

    logic channelNext;
    logic sampleNext;
    logic validNext;

    logic enableVplusReg;
    logic enableVminusReg;
    logic enableLnaReg;
    logic channelSelectReg;
    logic receivedSampleReg;
    logic sampleValidReg;
    logic readyReg;
    logic faultReg;

    sr_settle_counter #(
        .CountWidth(CountWidth)
    ) settleCounter (
        .Clock100Mhz(Clock100Mhz),
        .Reset      (Reset),
        .Load       (counterLoad),
        .LoadValue  (counterLoadValue),
        .Done       (counterDone)
    );

    // A rail drop while the LNA is powered outranks both a released request and counter expiry.
    always_comb begin
        nextState        = state;
        counterLoad      = 1'b0;
        counterLoadValue = '0;
        channelNext      = CH_1236;
        sampleNext       = 1'b0;
        validNext        = 1'b0;

        case (state)
            OFF: begin
                if (radio.PowerRequest) begin
                    nextState        = RAILS_UP;
                    counterLoad      = 1'b1;
                    counterLoadValue = SettleLoad;
                end
            end
            RAILS_UP: begin
                if (!radio.PowerRequest) begin
                    nextState        = RAMP_DOWN;
                    counterLoad      = 1'b1;
                    counterLoadValue = RampDownLoad;
                end else if (counterDone) begin
                    if (radio.RailGood) begin
                        nextState        = LNA_UP;
                        counterLoad      = 1'b1;
                        counterLoadValue = LnaSettleLoad;
                    end else begin
                        nextState = FAULT;
                    end
                end
            end
            LNA_UP, RECEIVE: begin
                if (!radio.RailGood) begin
                    nextState = FAULT;
                end else if (!radio.PowerRequest) begin
                    nextState        = RAMP_DOWN;
                    counterLoad      = 1'b1;
                    counterLoadValue = RampDownLoad;
                end else if (counterDone) begin
                    nextState        = RECEIVE;
                    counterLoad      = 1'b1;
                    counterLoadValue = DwellLoad;
                end
            end
            RAMP_DOWN: begin
                if (counterDone) begin
                    nextState = OFF;
                end
            end
            FAULT: begin
                if (!radio.PowerRequest) begin
                    nextState = OFF;
                end
            end
            default: begin
                nextState = OFF;
            end
        endcase

        // Each dwell starts with a blanking cycle: on entry and on every channel toggle.
        if (nextState == RECEIVE) begin
            if (state != RECEIVE) begin
                channelNext = CH_1236;
            end else if (counterDone) begin
                channelNext = ~channelSelectReg;
            end else begin
                channelNext = channelSelectReg;
            end
            validNext  = (state == RECEIVE) && !counterDone;
            sampleNext = (channelNext == CH_5478) ? radio.Received5478 : radio.Received1236;
        end
    end

    // Outputs are registered from the next state so they change together with it.
    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            state             <= OFF;
            enableVplusReg    <= 1'b0;
            enableVminusReg   <= 1'b0;
            enableLnaReg      <= 1'b0;
            channelSelectReg  <= CH_1236;
            receivedSampleReg <= 1'b0;
            sampleValidReg    <= 1'b0;
            readyReg          <= 1'b0;
            faultReg          <= 1'b0;
        end else begin
            state             <= nextState;
            enableVplusReg    <= (nextState == RAILS_UP) || (nextState == LNA_UP) ||
                                 (nextState == RECEIVE)  || (nextState == RAMP_DOWN);
            enableVminusReg   <= (nextState == RAILS_UP) || (nextState == LNA_UP) ||
                                 (nextState == RECEIVE)  || (nextState == RAMP_DOWN);
            enableLnaReg      <= (nextState == LNA_UP) || (nextState == RECEIVE);
            channelSelectReg  <= channelNext;
            receivedSampleReg <= sampleNext;
            sampleValidReg    <= validNext;
            readyReg          <= (nextState == RECEIVE);
            faultReg          <= (nextState == FAULT);
        end
    end

    assign radio.EnableVplus    = enableVplusReg;
    assign radio.EnableVminus   = enableVminusReg;
    assign radio.EnableLna      = enableLnaReg;
    assign radio.ChannelSelect  = channelSelectReg;
    assign radio.ReceivedSample = receivedSampleReg;
    assign radio.SampleValid    = sampleValidReg;
    assign radio.Ready          = readyReg;
    assign radio.Fault          = faultReg;

endmodule

// File: tb/tb_split_radio_power_sequencer.sv
// Directed scenarios for the split-radio sequencer; expectations are queued per cycle
// and per valid sample, and a monitor process pops and compares them as the DUT runs.
module tb_split_radio_power_sequencer;

    localparam int SETTLE     = 4;
    localparam int LNA_SETTLE = 3;
    localparam int DWELL      = 5;
    localparam int RAMP       = 2;

    // Output vector bit order: Vplus Vminus Lna ChannelSelect Sample Valid Ready Fault
    localparam logic [7:0] V_OFF   = 8'h00;
    localparam logic [7:0] V_RAILS = 8'hC0;
    localparam logic [7:0] V_LNA   = 8'hE0;
    localparam logic [7:0] V_FAULT = 8'h01;
    localparam logic [7:0] M_ALL   = 8'hFF;
    localparam logic [7:0] M_CORE  = 8'hE7;

    typedef struct {
        int         cycle;
        string      name;
        logic [7:0] value;
        logic [7:0] mask;
    } expect_t;

    logic clock = 1'b0;
    logic reset;

    expect_t    expectQ[$];
    logic       sampleQ[$];
    int         cyc        = 0;
    int         base       = 0;
    int         checkCount = 0;
    int         passCount  = 0;
    expect_t    mon;
    logic [7:0] outs;
    logic       expSample;

    always #5 clock = ~clock;

    split_radio_power_sequencer_if radio();

    split_radio_power_sequencer #(
        .SettleCycles   (SETTLE),
        .LnaSettleCycles(LNA_SETTLE),
        .DwellCycles    (DWELL),
        .RampDownCycles (RAMP),
        .CountWidth     (16)
    ) dut (
        .Clock100Mhz(clock),
        .Reset      (reset),
        .radio      (radio)
    );

    function automatic logic [7:0] rx(input logic ch, input logic smp, input logic vld);
        return {3'b111, ch, smp, vld, 2'b10};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected, input logic [7:0] mask);
        checkCount++;
        if ((actual & mask) === (expected & mask)) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b expected %b (mask %b) at tb cycle %0d",
                     name, actual, expected, mask, cyc);
        end
    endtask

    task automatic applyStimulus(input logic pr, input logic rg, input logic r1236, input logic r5478);
        radio.PowerRequest = pr;
        radio.RailGood     = rg;
        radio.Received1236 = r1236;
        radio.Received5478 = r5478;
    endtask

    task automatic expectAt(input int n, input string name, input logic [7:0] v, input logic [7:0] m);
        expect_t e;
        e.cycle = base + n;
        e.name  = name;
        e.value = v;
        e.mask  = m;
        expectQ.push_back(e);
    endtask

    task automatic waitCycle(input int n);
        while (cyc < base + n) @(negedge clock);
    endtask

    task automatic startScenario();
        base = cyc;
    endtask

    // Monitor: checks queued per-cycle vectors and, independently, every valid sample.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            outs = {radio.EnableVplus, radio.EnableVminus, radio.EnableLna, radio.ChannelSelect,
                    radio.ReceivedSample, radio.SampleValid, radio.Ready, radio.Fault};
            while (expectQ.size() > 0 && expectQ[0].cycle <= cyc) begin
                mon = expectQ.pop_front();
                if (mon.cycle < cyc) begin
                    checkCount++;
                    $display("[TB] FAIL %s: never sampled, required %b at tb cycle %0d",
                             mon.name, mon.value, mon.cycle);
                end else begin
                    checkOutput(mon.name, outs, mon.value, mon.mask);
                end
            end
            if (radio.SampleValid === 1'b1) begin
                if (sampleQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL sample_unexpected: got valid sample %b, required none at tb cycle %0d",
                             radio.ReceivedSample, cyc);
                end else begin
                    expSample = sampleQ.pop_front();
                    checkOutput("sample", {7'b0, radio.ReceivedSample}, {7'b0, expSample}, 8'h01);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset state
        @(negedge clock);
        startScenario();
        expectAt(1, "reset_state", V_OFF, M_ALL);
        expectAt(2, "reset_state_hold", V_OFF, M_ALL);
        waitCycle(3);
        reset = 1'b0;
        waitCycle(5);

        // Power-up and sampling
        startScenario();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        expectAt(1,  "pwr_rails",      V_RAILS, M_CORE);
        expectAt(4,  "pwr_rails_hold", V_RAILS, M_CORE);
        expectAt(5,  "pwr_lna",        V_LNA,   M_CORE);
        expectAt(7,  "pwr_lna_hold",   V_LNA,   M_CORE);
        expectAt(8,  "rx_entry",       rx(1'b0, 1'b1, 1'b0), M_ALL);
        expectAt(9,  "rx_ch0_valid",   rx(1'b0, 1'b1, 1'b1), M_ALL);
        expectAt(12, "rx_ch0_end",     rx(1'b0, 1'b1, 1'b1), M_ALL);
        expectAt(13, "rx_toggle1",     rx(1'b1, 1'b0, 1'b0), M_ALL);
        expectAt(14, "rx_ch1_valid",   rx(1'b1, 1'b0, 1'b1), M_ALL);
        expectAt(17, "rx_ch1_end",     rx(1'b1, 1'b0, 1'b1), M_ALL);
        expectAt(18, "rx_toggle2",     rx(1'b0, 1'b1, 1'b0), M_ALL);
        expectAt(19, "pwr_ramp_lna_off", V_RAILS, M_CORE);
        expectAt(20, "pwr_ramp_hold",  V_RAILS, M_CORE);
        expectAt(21, "pwr_ramp_off",   V_OFF,   M_ALL);
        for (int i = 0; i < 4; i++) sampleQ.push_back(1'b1);
        for (int i = 0; i < 4; i++) sampleQ.push_back(1'b0);
        waitCycle(18);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        waitCycle(23);

        // Ramp-down with a request re-raised before Off
        startScenario();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        expectAt(8,  "ramp_rx_entry",   rx(1'b0, 1'b0, 1'b0), M_ALL);
        expectAt(10, "ramp_rx_valid",   rx(1'b0, 1'b0, 1'b1), M_ALL);
        expectAt(11, "ramp_lna_off",    V_RAILS, M_CORE);
        expectAt(12, "ramp_hold",       V_RAILS, M_CORE);
        expectAt(13, "ramp_off",        V_OFF,   M_ALL);
        expectAt(14, "rearm_rails",     V_RAILS, M_CORE);
        expectAt(15, "rearm_abort",     V_RAILS, M_CORE);
        expectAt(17, "rearm_abort_off", V_OFF,   M_ALL);
        sampleQ.push_back(1'b0);
        sampleQ.push_back(1'b0);
        waitCycle(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        waitCycle(12);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        waitCycle(14);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        waitCycle(19);

        // Missing rail at end of settle
        startScenario();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectAt(1, "miss_rails",      V_RAILS, M_CORE);
        expectAt(4, "miss_rails_hold", V_RAILS, M_CORE);
        expectAt(5, "fault_missing_rail", V_FAULT, M_CORE);
        expectAt(7, "fault_hold",      V_FAULT, M_CORE);
        expectAt(8, "fault_cleared",   V_OFF,   M_ALL);
        waitCycle(7);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitCycle(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        waitCycle(12);

        // Rail drop while receiving, with the request falling on the same cycle
        startScenario();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        expectAt(10, "drop_rx",         rx(1'b0, 1'b1, 1'b1), M_ALL);
        expectAt(11, "fault_rail_drop", V_FAULT, M_CORE);
        expectAt(12, "drop_fault_exit", V_OFF,   M_ALL);
        sampleQ.push_back(1'b1);
        sampleQ.push_back(1'b1);
        waitCycle(10);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitCycle(12);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        waitCycle(14);

        // Reset in the middle of LnaUp, then a clean restart
        startScenario();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        expectAt(5,  "rst_lna",        V_LNA,   M_CORE);
        expectAt(6,  "rst_lna_hold",   V_LNA,   M_CORE);
        expectAt(7,  "reset_mid_lna",  V_OFF,   M_ALL);
        expectAt(8,  "restart_rails",  V_RAILS, M_CORE);
        expectAt(11, "restart_rails_hold", V_RAILS, M_CORE);
        expectAt(12, "restart_lna",    V_LNA,   M_CORE);
        expectAt(14, "restart_lna_hold", V_LNA, M_CORE);
        expectAt(15, "restart_ready",  rx(1'b0, 1'b1, 1'b0), M_ALL);
        expectAt(17, "final_ramp",     V_RAILS, M_CORE);
        expectAt(19, "final_off",      V_OFF,   M_ALL);
        sampleQ.push_back(1'b1);
        waitCycle(6);
        reset = 1'b1;
        waitCycle(7);
        reset = 1'b0;
        waitCycle(16);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        waitCycle(21);

        checkOutput("samples_drained", 8'(sampleQ.size()), 8'd0, M_ALL);
        checkOutput("vectors_drained", 8'(expectQ.size()), 8'd0, M_ALL);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
